// File: rtl/slifo_dual_mode.sv
// slifo_dual_mode: one storage array used as a stack or a queue, selected at run time.
// Defining SLIFO_PEEK_EN adds a combinational peek port (peek_data/peek_valid).
module slifo_dual_mode #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned POINTER_WIDTH = 4,
  parameter int unsigned TH_LEVEL      = 2 ** (POINTER_WIDTH - 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     clear,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     th_we,
  input  logic [POINTER_WIDTH:0]   low_th,
  input  logic [POINTER_WIDTH:0]   high_th,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     out_valid,
  output logic                     active_mode,
  output logic [POINTER_WIDTH:0]   count,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     buf_low_th,
  output logic                     buf_high_th,
  output logic                     buf_ov,
  output logic                     buf_ud
`ifdef SLIFO_PEEK_EN
  ,
  output logic [DATA_WIDTH-1:0]    peek_data,
  output logic                     peek_valid
`endif
);

  localparam int unsigned DEPTH = 2 ** POINTER_WIDTH;
  localparam logic [POINTER_WIDTH:0]   FULL_CNT = {1'b1, {POINTER_WIDTH{1'b0}}};
  localparam logic [POINTER_WIDTH:0]   TH_RST   = (POINTER_WIDTH + 1)'(TH_LEVEL);
  localparam logic [POINTER_WIDTH:0]   CNT_ONE  = (POINTER_WIDTH + 1)'(1);
  localparam logic [POINTER_WIDTH-1:0] PTR_ONE  = POINTER_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [POINTER_WIDTH:0]   count_q, count_d;
  logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     active_mode_q, active_mode_d;
  logic                     ov_q, ov_d;
  logic                     ud_q, ud_d;
  logic [POINTER_WIDTH:0]   low_th_q, low_th_d;
  logic [POINTER_WIDTH:0]   high_th_q, high_th_d;

  logic                     fwd, fifo_rw, we, re;
  logic [POINTER_WIDTH-1:0] waddr, raddr;

  assign buf_empty   = (count_q == '0);
  assign buf_full    = (count_q == FULL_CNT);
  assign buf_low_th  = (count_q < low_th_q);
  assign buf_high_th = (count_q >= high_th_q);

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign active_mode = active_mode_q;
  assign count       = count_q;
  assign buf_ov      = ov_q;
  assign buf_ud      = ud_q;

  // Simultaneous wr&rd bypasses memory in LIFO mode, and in FIFO mode only when empty.
  always_comb begin
    fwd     = wr & rd & (~active_mode_q | buf_empty);
    fifo_rw = wr & rd & active_mode_q & ~buf_empty;
    we      = ~clear & ~fwd & (fifo_rw | (wr & ~buf_full));
    re      = ~clear & ~fwd & (fifo_rw | (rd & ~buf_empty));
    waddr   = active_mode_q ? wr_ptr_q : count_q[POINTER_WIDTH-1:0];
    raddr   = active_mode_q ? rd_ptr_q : (count_q[POINTER_WIDTH-1:0] - PTR_ONE);
  end

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ov_d          = ov_q;
    ud_d          = ud_q;
    data_out_d    = data_out_q;
    out_valid_d   = ~clear & (fwd | re);
    active_mode_d = (buf_empty & ~we) ? mode : active_mode_q;
    low_th_d      = th_we ? low_th : low_th_q;
    high_th_d     = th_we ? high_th : high_th_q;

    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ov_d     = 1'b0;
      ud_d     = 1'b0;
    end else begin
      if (we && !re) begin
        count_d = count_q + CNT_ONE;
      end else if (re && !we) begin
        count_d = count_q - CNT_ONE;
      end
      if (active_mode_q) begin
        if (we) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (re) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr && buf_full && !rd) begin
        ov_d = 1'b1;
      end else if (re) begin
        ov_d = 1'b0;
      end
      if (rd && buf_empty && !wr) begin
        ud_d = 1'b1;
      end else if (we) begin
        ud_d = 1'b0;
      end
      if (fwd) begin
        data_out_d = data_in;
      end else if (re) begin
        data_out_d = mem[raddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
      active_mode_q <= 1'b0;
      ov_q          <= 1'b0;
      ud_q          <= 1'b0;
      low_th_q      <= TH_RST;
      high_th_q     <= TH_RST;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      data_out_q    <= data_out_d;
      out_valid_q   <= out_valid_d;
      active_mode_q <= active_mode_d;
      ov_q          <= ov_d;
      ud_q          <= ud_d;
      low_th_q      <= low_th_d;
      high_th_q     <= high_th_d;
    end
  end

`ifdef SLIFO_PEEK_EN
  assign peek_data  = mem[raddr];
  assign peek_valid = ~buf_empty;
`endif

endmodule

// File: tb/tb_slifo_dual_mode.sv
// Directed self-checking bench for slifo_dual_mode (default build, DATA_WIDTH=8, POINTER_WIDTH=4).
module tb_slifo_dual_mode;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       clear;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic       th_we;
  logic [4:0] low_th;
  logic [4:0] high_th;
  logic [7:0] data_out;
  logic       out_valid;
  logic       active_mode;
  logic [4:0] count;
  logic       buf_empty;
  logic       buf_full;
  logic       buf_low_th;
  logic       buf_high_th;
  logic       buf_ov;
  logic       buf_ud;

  int checks = 0;
  int errors = 0;

  slifo_dual_mode #(
    .DATA_WIDTH   (8),
    .POINTER_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .clear      (clear),
    .wr         (wr),
    .rd         (rd),
    .data_in    (data_in),
    .th_we      (th_we),
    .low_th     (low_th),
    .high_th    (high_th),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .active_mode(active_mode),
    .count      (count),
    .buf_empty  (buf_empty),
    .buf_full   (buf_full),
    .buf_low_th (buf_low_th),
    .buf_high_th(buf_high_th),
    .buf_ov     (buf_ov),
    .buf_ud     (buf_ud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr    = 1'b0;
    rd    = 1'b0;
    clear = 1'b0;
    th_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1; rd = 1'b0; data_in = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; data_in = 8'h00; low_th = 5'd0; high_th = 5'd0;
    idle();
    #12;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", buf_empty); end
    checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", buf_full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", data_out); end
    checks++; if (active_mode !== 1'b0) begin errors++; $display("FAIL rst_mode got %b want 0", active_mode); end
    checks++; if ({buf_ov, buf_ud} !== 2'b00) begin errors++; $display("FAIL rst_ovud got %b want 00", {buf_ov, buf_ud}); end
    checks++; if ({buf_low_th, buf_high_th} !== 2'b10) begin errors++; $display("FAIL rst_th got %b want 10", {buf_low_th, buf_high_th}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lifo();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) push(vals[i]);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL lifo_fill_count got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (data_out !== vals[2-i]) begin errors++; $display("FAIL lifo_pop_data[%0d] got %h want %h", i, data_out, vals[2-i]); end
      checks++; if (count !== 5'(2 - i)) begin errors++; $display("FAIL lifo_pop_count[%0d] got %0d want %0d", i, count, 2 - i); end
    end
    rd = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lifo_valid_drop got %b want 0", out_valid); end
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL lifo_data_hold got %h want 11", data_out); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b want 1", buf_empty); end
  endtask

  task automatic test_fifo();
    logic [7:0] exp;
    mode = 1'b1;
    tick();
    checks++; if (active_mode !== 1'b1) begin errors++; $display("FAIL fifo_mode got %b want 1", active_mode); end
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      exp = 8'h11 * 8'(i + 1);
      checks++; if (data_out !== exp || out_valid !== 1'b1) begin
        errors++; $display("FAIL fifo_pop[%0d] got %h/%b want %h/1", i, data_out, out_valid, exp);
      end
    end
    rd = 1'b0;
    push(8'h40);
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1; data_in = 8'h50 + 8'(i);
      tick();
      exp = (i == 0) ? 8'h40 : 8'h50 + 8'(i - 1);
      checks++; if (data_out !== exp || out_valid !== 1'b1) begin
        errors++; $display("FAIL fifo_pair_data[%0d] got %h/%b want %h/1", i, data_out, out_valid, exp);
      end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL fifo_pair_count[%0d] got %0d want 1", i, count); end
    end
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (data_out !== 8'h63) begin errors++; $display("FAIL fifo_last got %h want 63", data_out); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fifo_drain_count got %0d want 0", count); end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    checks++; if (count !== 5'd16 || buf_full !== 1'b1) begin
      errors++; $display("FAIL full_fill got %0d/%b want 16/1", count, buf_full);
    end
    wr = 1'b1; rd = 1'b0; data_in = 8'hEE;
    tick();
    wr = 1'b0;
    checks++; if (buf_ov !== 1'b1) begin errors++; $display("FAIL full_ov_set got %b want 1", buf_ov); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_ov_count got %0d want 16", count); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL full_intact got %h want 80", data_out); end
    checks++; if (buf_ov !== 1'b0) begin errors++; $display("FAIL full_ov_clear got %b want 0", buf_ov); end
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_pop_count got %0d want 15", count); end
    push(8'h90);
    wr = 1'b1; rd = 1'b1; data_in = 8'h91;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++; if (data_out !== 8'h81 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_rw_data got %h/%b want 81/1", data_out, out_valid);
    end
    checks++; if (count !== 5'd16 || buf_ov !== 1'b0) begin
      errors++; $display("FAIL full_rw_count got %0d/%b want 16/0", count, buf_ov);
    end
    for (int k = 0; k < 16; k++) begin
      rd = 1'b1;
      tick();
      exp = (k < 14) ? 8'h82 + 8'(k) : 8'h90 + 8'(k - 14);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", k, data_out, exp); end
    end
    rd = 1'b0;
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b want 1", buf_empty); end
  endtask

  task automatic test_underflow();
    mode = 1'b0;
    tick();
    checks++; if (active_mode !== 1'b0) begin errors++; $display("FAIL ud_mode got %b want 0", active_mode); end
    rd = 1'b1;
    tick();
    checks++; if (buf_ud !== 1'b1) begin errors++; $display("FAIL ud_set got %b want 1", buf_ud); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ud_valid got %b want 0", out_valid); end
    wr = 1'b1; data_in = 8'hA5;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++; if (data_out !== 8'hA5 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fwd_data got %h/%b want a5/1", data_out, out_valid);
    end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fwd_count got %0d want 0", count); end
    push(8'h12);
    checks++; if (buf_ud !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL ud_clear got %b/%0d want 0/1", buf_ud, count);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL ud_pop got %h want 12", data_out); end
  endtask

  task automatic test_mode_lock();
    push(8'h01); push(8'h02); push(8'h03);
    mode = 1'b1;
    tick();
    checks++; if (active_mode !== 1'b0) begin errors++; $display("FAIL lock_hold got %b want 0", active_mode); end
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      checks++; if (data_out !== 8'(3 - i) || active_mode !== 1'b0) begin
        errors++; $display("FAIL lock_pop[%0d] got %h/%b want %h/0", i, data_out, active_mode, 8'(3 - i));
      end
    end
    rd = 1'b0;
    tick();
    checks++; if (active_mode !== 1'b1) begin errors++; $display("FAIL lock_switch got %b want 1", active_mode); end
  endtask

  task automatic test_thresholds();
    th_we = 1'b1; low_th = 5'd4; high_th = 5'd12;
    tick();
    th_we = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      push(8'hC0 + 8'(n));
      checks++; if (buf_low_th !== (n < 4) || buf_high_th !== (n >= 12)) begin
        errors++; $display("FAIL th_at_%0d got %b%b want %b%b", n, buf_low_th, buf_high_th, n < 4, n >= 12);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (count !== 5'd0 || buf_full !== 1'b0) begin
      errors++; $display("FAIL clear_full got %0d/%b want 0/0", count, buf_full);
    end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL clear_data_kept got %h want 01", data_out); end
    for (int n = 0; n < 7; n++) push(8'hB0 + 8'(n));
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL clear_pre got %0d want 7", count); end
    clear = 1'b1; wr = 1'b1; data_in = 8'hFF;
    tick();
    clear = 1'b0; wr = 1'b0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_at_7 got %0d/%b want 0/0", count, out_valid);
    end
    for (int n = 0; n < 5; n++) push(8'hD0 + 8'(n));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (data_out !== 8'hD0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_ptr got %h/%b want d0/1", data_out, out_valid);
    end
    rst_n = 1'b0;
    #2;
    checks++; if (count !== 5'd0 || buf_empty !== 1'b1) begin
      errors++; $display("FAIL async_count got %0d/%b want 0/1", count, buf_empty);
    end
    checks++; if (out_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL async_data got %b/%h want 0/00", out_valid, data_out);
    end
    checks++; if (active_mode !== 1'b0) begin errors++; $display("FAIL async_mode got %b want 0", active_mode); end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) push(8'hE0 + 8'(n));
    checks++; if (count !== 5'd4 || buf_low_th !== 1'b1 || buf_high_th !== 1'b0) begin
      errors++; $display("FAIL th_after_rst got %0d/%b%b want 4/10", count, buf_low_th, buf_high_th);
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_fifo();
    test_full();
    test_underflow();
    test_mode_lock();
    test_thresholds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slifo_dual_mode.md
Name: slifo_dual_mode

Overview:
- Parametrised successor to the synchronous LIFO: one storage array served as a LIFO (stack) or a FIFO (queue), selected at run time.
- Adds an occupancy count, runtime thresholds, sticky overflow/underflow flags, a synchronous flush, and a registered read-data port with a valid strobe.
- Sits between a producer and a consumer in the same clock domain as a general stack/queue buffer.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- POINTER_WIDTH, 4, depth = 2**POINTER_WIDTH entries; count is POINTER_WIDTH+1 bits.
- TH_LEVEL, 2**(POINTER_WIDTH-1), reset value of both threshold registers.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  requested mode: 0 = LIFO, 1 = FIFO.
- clear  input  1  synchronous flush.
- wr  input  1  push/write request.
- rd  input  1  pop/read request.
- data_in  input  DATA_WIDTH  write data.
- th_we  input  1  load low_th/high_th into the threshold registers.
- low_th  input  POINTER_WIDTH+1  low threshold value.
- high_th  input  POINTER_WIDTH+1  high threshold value.
- data_out  output  DATA_WIDTH  registered read data.
- out_valid  output  1  data_out updated this cycle.
- active_mode  output  1  mode currently in force.
- count  output  POINTER_WIDTH+1  occupancy, 0..2**POINTER_WIDTH.
- buf_empty  output  1  count == 0.
- buf_full  output  1  count == 2**POINTER_WIDTH.
- buf_low_th  output  1  count < low threshold register.
- buf_high_th  output  1  count >= high threshold register.
- buf_ov  output  1  sticky overflow flag.
- buf_ud  output  1  sticky underflow flag.

Behaviour:
- Reset values (rst_n=0, asynchronous): count=0; all pointers 0; data_out=0; out_valid=0; active_mode=0 (LIFO); buf_ov=0; buf_ud=0; both threshold registers = TH_LEVEL. Memory contents are not reset.
- Mode: active_mode loads mode only on a cycle where count==0 and no write is accepted. A mode change requested while non-empty is ignored until the buffer drains.
- Accept rules:
  - we = wr & ~buf_full.
  - re = rd & ~buf_empty.
  - LIFO: wr&rd together is a forward. data_in goes to data_out, out_valid=1, count unchanged, memory not written, whatever the count (including empty and full).
  - FIFO: wr&rd with count>0 performs a write and a read, count unchanged. At full this is allowed: the read frees a slot, so the write is accepted. With count==0 it is a forward as in LIFO.
- LIFO order: push writes mem[count] and increments count. Pop reads mem[count-1] and decrements count.
- FIFO order: write at wr_ptr, read at rd_ptr. Both pointers are POINTER_WIDTH bits and wrap modulo depth. count is tracked separately.
- Latency: data_out and out_valid are registered, 1 cycle after the accepting edge. out_valid is high exactly one cycle per accepted read or forward. data_out holds its value otherwise.
- Flags:
  - buf_empty, buf_full, buf_low_th, buf_high_th are combinational from count and the threshold registers.
  - Threshold compares are unsigned, POINTER_WIDTH+1 bits.
- Overflow: buf_ov sets on wr with buf_full and no simultaneous read/forward. It clears on any accepted read. Set has priority over clear in the same cycle.
- Underflow: buf_ud sets on rd with buf_empty and no wr. It clears on any accepted write. Set has priority.
- clear: next edge sets count=0, pointers=0, out_valid=0, buf_ov=0, buf_ud=0. It is a data-path no-op otherwise and overrides wr/rd that cycle. data_out and the thresholds are kept.
- th_we: registers low_th/high_th at the next edge, independent of all other activity.

Optional Feature:
- Macro: SLIFO_PEEK_EN.
- Defined: adds outputs peek_data [DATA_WIDTH] and peek_valid [1], both combinational.
  - peek_data = the element the next pop would return: mem[count-1] in LIFO, mem[rd_ptr] in FIFO.
  - peek_valid = ~buf_empty.
  - peek_data is don't-care when peek_valid=0.
- Undefined: neither port exists and no peek read mux is built.

Test Plan:
- LIFO push 0x11,0x22,0x33 then 3 pops -> out_valid pulses with data_out 0x33,0x22,0x11, each 1 cycle after its pop; count 3->0; buf_empty=1.
- mode=1 after empty, push 0x11,0x22,0x33, pop 3 -> data_out 0x11,0x22,0x33. Then 20 push/pop pairs -> pointer wrap, data in order, count steady.
- Fill to 16 (POINTER_WIDTH=4), then wr alone -> buf_full=1, buf_ov=1, count 16, memory intact. Next pop clears buf_ov. FIFO wr&rd at full -> count stays 16.
- Empty, rd alone -> buf_ud=1, out_valid=0. LIFO wr&rd with data_in=0xA5 -> data_out=0xA5, out_valid=1, count 0. Next write clears buf_ud.
- Push 3 in LIFO, set mode=1 -> active_mode stays 0 until drained; after pops to empty, active_mode=1 the following edge.
- th_we with low=4, high=12, fill 0..16 -> buf_low_th=1 for count<4, buf_high_th=1 for count>=12. Assert rst_n mid-fill -> all outputs at reset values immediately, without waiting for a clock edge. Pulse clear at count 7 -> count 0 next edge.
